// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, status and memory signals of the arbiter.
// slave = arbiter side, master = requesters/memory/bench side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              owner;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_ack, dbg_ack, rdata, busy, owner,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_ack, dbg_ack, rdata, busy, owner,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (cpu/dbg) arbiter onto one sync-read memory.
// Ports: clk, rst (sync, active-high), bus (mem_arbiter_if.slave).
// Macro MEM_ARBITER_FIXED_PRIO_EN: cpu always wins ties.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [3:0]        r_cnt;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
  logic              r_last;
`endif

  logic              w_any;
  logic              w_both;
  logic              w_win;
  logic              w_grant;
  logic              w_mem_en;
  logic              w_busy;
  logic              w_resp;

  // Winner select: a lone requester wins; ties are broken
  // either by round-robin or by fixed cpu priority.
  always_comb begin
    w_any  = bus.cpu_req | bus.dbg_req;
    w_both = bus.cpu_req & bus.dbg_req;
    w_win  = 1'b0;
    unique case (1'b1)
      w_both: begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
        w_win = 1'b0;
`else
        w_win = ~r_last;
`endif
      end
      (bus.dbg_req & ~bus.cpu_req): w_win = 1'b1;
      default: w_win = 1'b0;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_grant  = 1'b0;
    w_mem_en = 1'b0;
    w_busy   = 1'b1;
    w_resp   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_any) begin
          w_grant = 1'b1;
          w_next  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_mem_en = 1'b1;
        w_next   = (WS == 4'd0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt <= 4'd1)
          w_next = S_RESP;
      end
      S_RESP: begin
        w_resp = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_owner <= w_win;
        r_we    <= w_win ? bus.dbg_we : bus.cpu_we;
        r_addr  <= w_win ? bus.dbg_addr : bus.cpu_addr;
        r_wdata <= w_win ? bus.dbg_wdata : bus.cpu_wdata;
      end
      if (r_state == S_ACCESS)
        r_cnt <= WS;
      else if (r_state == S_WAIT)
        r_cnt <= r_cnt - 4'd1;
      if (r_state == S_RESP)
        r_rdata <= bus.mem_rdata;
    end
  end

`ifndef MEM_ARBITER_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst)
      r_last <= 1'b1;
    else if (w_grant)
      r_last <= w_win;
  end
`endif

  // The memory word only appears one edge after mem_en, so
  // during RESP the live read data is forwarded; the register
  // keeps it stable once the arbiter is back in IDLE.
  assign bus.rdata     = w_resp ? bus.mem_rdata : r_rdata;
  assign bus.cpu_ack   = w_resp & ~r_owner;
  assign bus.dbg_ack   = w_resp & r_owner;
  assign bus.busy      = w_busy;
  assign bus.owner     = r_owner;
  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_en & r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (0 and 3 wait states) against a
// transaction-level reference model and a sync-read memory model.
module tb_mem_arbiter;

  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       c_req, c_we, g_req, g_we;
  logic [1:0][31:0] c_addr, c_wd, g_addr, g_wd;
  logic [1:0]       o_cack, o_gack, o_busy, o_own;
  logic [1:0]       o_men, o_mwe;
  logic [1:0][31:0] o_rd, o_ma, o_mwd;
  logic [31:0]      mrd0 = '0;
  logic [31:0]      mrd1 = '0;
  logic [31:0]      m0 [256];
  logic [31:0]      m1 [256];
  bit               v0 [256];
  bit               v1 [256];
  int               nen0 = 0;
  int               nen1 = 0;

  int          nvec;
  int          nerr;
  bit          lastm [2];
  logic [31:0] rm [2][256];
  bit          rv [2][256];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1 ();

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS0)
  ) u0 (
    .clk(clk), .rst(rst[0]), .bus(if0)
  );

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS1)
  ) u1 (
    .clk(clk), .rst(rst[1]), .bus(if1)
  );

  assign if0.cpu_req   = c_req[0];
  assign if0.cpu_we    = c_we[0];
  assign if0.cpu_addr  = c_addr[0];
  assign if0.cpu_wdata = c_wd[0];
  assign if0.dbg_req   = g_req[0];
  assign if0.dbg_we    = g_we[0];
  assign if0.dbg_addr  = g_addr[0];
  assign if0.dbg_wdata = g_wd[0];
  assign if0.mem_rdata = mrd0;
  assign if1.cpu_req   = c_req[1];
  assign if1.cpu_we    = c_we[1];
  assign if1.cpu_addr  = c_addr[1];
  assign if1.cpu_wdata = c_wd[1];
  assign if1.dbg_req   = g_req[1];
  assign if1.dbg_we    = g_we[1];
  assign if1.dbg_addr  = g_addr[1];
  assign if1.dbg_wdata = g_wd[1];
  assign if1.mem_rdata = mrd1;

  assign o_cack = {if1.cpu_ack, if0.cpu_ack};
  assign o_gack = {if1.dbg_ack, if0.dbg_ack};
  assign o_busy = {if1.busy, if0.busy};
  assign o_own  = {if1.owner, if0.owner};
  assign o_men  = {if1.mem_en, if0.mem_en};
  assign o_mwe  = {if1.mem_we, if0.mem_we};
  assign o_rd   = {if1.rdata, if0.rdata};
  assign o_ma   = {if1.mem_addr, if0.mem_addr};
  assign o_mwd  = {if1.mem_wdata, if0.mem_wdata};

  function automatic logic [31:0] finit(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {8'h5A, a, ~a, a};
  endfunction

  always @(posedge clk) begin
    if (if0.mem_en) begin
      nen0 <= nen0 + 1;
      if (if0.mem_we) begin
        m0[if0.mem_addr[7:0]] <= if0.mem_wdata;
        v0[if0.mem_addr[7:0]] <= 1'b1;
      end else begin
        mrd0 <= v0[if0.mem_addr[7:0]] ? m0[if0.mem_addr[7:0]]
                                      : finit(if0.mem_addr[7:0]);
      end
    end
  end

  always @(posedge clk) begin
    if (if1.mem_en) begin
      nen1 <= nen1 + 1;
      if (if1.mem_we) begin
        m1[if1.mem_addr[7:0]] <= if1.mem_wdata;
        v1[if1.mem_addr[7:0]] <= 1'b1;
      end else begin
        mrd1 <= v1[if1.mem_addr[7:0]] ? m1[if1.mem_addr[7:0]]
                                      : finit(if1.mem_addr[7:0]);
      end
    end
  end

  function automatic int nen(input int d);
    return (d == 0) ? nen0 : nen1;
  endfunction

  function automatic logic [31:0] refrd(input int d, input logic [31:0] a);
    return rv[d][a[7:0]] ? rm[d][a[7:0]] : finit(a[7:0]);
  endfunction

  // Arbitration rule: lone requester wins; a tie goes to the
  // port that did not win last time (or always cpu).
  function automatic int pick(input bit c, input bit g, input bit last);
    if (c && g) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
      return (last === 1'bx) ? 1 : 0;
`else
      return last ? 0 : 1;
`endif
    end
    return g ? 1 : 0;
  endfunction

  task automatic chk(input int d, input string tag,
                     input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s[dut%0d] observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic setreq(input int d, input int p, input logic rq,
                        input logic we, input logic [31:0] a,
                        input logic [31:0] wd);
    if (p == 0) begin
      c_req[d] = rq; c_we[d] = we; c_addr[d] = a; c_wd[d] = wd;
    end else begin
      g_req[d] = rq; g_we[d] = we; g_addr[d] = a; g_wd[d] = wd;
    end
  endtask

  task automatic chk_idle(input int d);
    chk(d, "idle_busy", o_busy[d], 1'b0);
    chk(d, "idle_ack", {o_cack[d], o_gack[d]}, 2'b00);
    chk(d, "idle_mem_en", o_men[d], 1'b0);
  endtask

  task automatic chk_reset(input int d);
    chk(d, "rst_busy", o_busy[d], 1'b0);
    chk(d, "rst_acks", {o_cack[d], o_gack[d]}, 2'b00);
    chk(d, "rst_owner", o_own[d], 1'b0);
    chk(d, "rst_mem_en_we", {o_men[d], o_mwe[d]}, 2'b00);
    chk(d, "rst_mem_addr", o_ma[d], 32'h0);
    chk(d, "rst_mem_wdata", o_mwd[d], 32'h0);
    chk(d, "rst_rdata", o_rd[d], 32'h0);
  endtask

  // Starts in an IDLE cycle (just after its falling edge) and
  // returns in the IDLE cycle after the last ack.
  task automatic serve(input int d, input bit con, input bit gon,
                       input bit glate,
                       input logic cwe, input logic [31:0] ca,
                       input logic [31:0] cd,
                       input logic gwe, input logic [31:0] ga,
                       input logic [31:0] gd);
    bit          pend [2];
    logic        wev [2];
    logic [31:0] av [2];
    logic [31:0] dv [2];
    int          w;
    int          ws;
    int          n0;
    int          ngr;
    ws = (d == 0) ? WS0 : WS1;
    wev[0] = cwe; av[0] = ca; dv[0] = cd;
    wev[1] = gwe; av[1] = ga; dv[1] = gd;
    pend[0] = con;
    pend[1] = gon && !glate;
    if (pend[0]) setreq(d, 0, 1'b1, cwe, ca, cd);
    if (pend[1]) setreq(d, 1, 1'b1, gwe, ga, gd);
    n0  = nen(d);
    ngr = 0;
    w   = 0;
    while (pend[0] || pend[1]) begin
      w = pick(pend[0], pend[1], lastm[d]);
      lastm[d] = (w == 1);
      ngr++;
      for (int k = 1; k <= 2 + ws; k++) begin
        @(negedge clk);
        chk(d, "busy", o_busy[d], 1'b1);
        chk(d, "owner", o_own[d], 32'(w));
        chk(d, "mem_en", o_men[d], (k == 1));
        chk(d, "mem_we", o_mwe[d], (k == 1) && wev[w]);
        chk(d, "mem_addr", o_ma[d], av[w]);
        if (k == 1) begin
          chk(d, "mem_wdata", o_mwd[d], dv[w]);
          setreq(d, w, 1'b1, ~wev[w], av[w] ^ 32'h89, ~dv[w]);
          if (glate && gon && !pend[1] && w == 0) begin
            pend[1] = 1'b1;
            setreq(d, 1, 1'b1, gwe, ga, gd);
          end
        end
        if (k == 2 + ws) begin
          chk(d, "cpu_ack", o_cack[d], (w == 0));
          chk(d, "dbg_ack", o_gack[d], (w == 1));
          if (!wev[w]) begin
            chk(d, "rdata", o_rd[d], refrd(d, av[w]));
          end else begin
            rm[d][av[w][7:0]] = dv[w];
            rv[d][av[w][7:0]] = 1'b1;
          end
          setreq(d, w, 1'b0, 1'b0, 32'h0, 32'h0);
          pend[w] = 1'b0;
        end else begin
          chk(d, "no_ack", {o_cack[d], o_gack[d]}, 2'b00);
        end
      end
      @(negedge clk);
      chk_idle(d);
      if (!wev[w])
        chk(d, "rdata_hold", o_rd[d], refrd(d, av[w]));
    end
    chk(d, "mem_en_count", 32'(nen(d) - n0), 32'(ngr));
  endtask

  task automatic rand_serve(input int d);
    int mode;
    mode = $urandom_range(0, 3);
    serve(d, mode != 1, mode != 0, mode == 3,
          1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom,
          1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk_idle(d);
    end
  endtask

  initial begin
    int n0;
    nvec = 0;
    nerr = 0;
    rst  = 2'b11;
    c_req = '0; c_we = '0; c_addr = '0; c_wd = '0;
    g_req = '0; g_we = '0; g_addr = '0; g_wd = '0;
    lastm[0] = 1'b1;
    lastm[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst = 2'b00;
    @(negedge clk);
    chk_idle(0);
    chk_idle(1);

    // both ports requesting straight out of reset
    serve(0, 1, 1, 0, 0, 32'h31, 0, 1, 32'h32, 32'hA1B2C3D4);
    serve(0, 1, 1, 0, 0, 32'h32, 0, 0, 32'h33, 0);
    serve(1, 1, 1, 0, 1, 32'h40, 32'h0BADF00D, 0, 32'h40, 0);
    serve(1, 1, 1, 0, 0, 32'h41, 0, 0, 32'h42, 0);

    // cpu read of 0x10, no wait states
    serve(0, 1, 0, 0, 0, 32'h10, 0, 0, 0, 0);

    // dbg write with wait states, then read back
    serve(1, 0, 1, 0, 0, 0, 0, 1, 32'h20, 32'h12345678);
    serve(1, 1, 0, 0, 0, 32'h20, 0, 0, 0, 0);

    // addr 0x10 scrambled to 0x99 after grant
    serve(1, 1, 0, 0, 0, 32'h10, 0, 0, 0, 0);

    // dbg raised while cpu is in ACCESS
    serve(0, 1, 1, 1, 0, 32'h05, 0, 1, 32'h06, 32'h600D600D);
    serve(1, 1, 1, 1, 1, 32'h07, 32'h77, 0, 32'h07, 0);

    // reset during WAIT of a cpu write
    n0 = nen(1);
    setreq(1, 0, 1'b1, 1'b1, 32'h50, 32'hCAFEF00D);
    @(negedge clk);
    chk(1, "rst_t_access", o_men[1], 1'b1);
    @(negedge clk);
    chk(1, "rst_t_wait", {o_busy[1], o_men[1]}, 2'b10);
    rst[1] = 1'b1;
    setreq(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    rm[1][8'h50] = 32'hCAFEF00D;
    rv[1][8'h50] = 1'b1;
    @(negedge clk);
    chk_reset(1);
    rst[1] = 1'b0;
    lastm[1] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk_idle(1);
      chk(1, "post_rst_mem_we", o_mwe[1], 1'b0);
    end
    chk(1, "rst_en_count", 32'(nen(1) - n0), 32'd1);
    serve(1, 1, 1, 0, 0, 32'h50, 0, 0, 32'h51, 0);

    for (int i = 0; i < 24; i++) rand_serve(0);
    for (int i = 0; i < 24; i++) rand_serve(1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter WAIT_STATES, default 0, extra memory cycles per access, legal range 0..15.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W, cpu_wdata in DATA_W, cpu_ack out 1: CPU requester port.
REQ-007 SHALL have ports dbg_req in 1, dbg_we in 1, dbg_addr in ADDR_W, dbg_wdata in DATA_W, dbg_ack out 1: debug/loader requester port.
REQ-008 SHALL have port rdata  out  DATA_W  read data returned to the current owner.
REQ-009 SHALL have ports busy out 1 (access in progress) and owner out 1 (0=cpu, 1=dbg).
REQ-010 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W: single-port memory with 1-cycle synchronous read.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP.
REQ-012 IDLE: if any req high, SHALL pick a winner, latch its we/addr/wdata and owner, go to ACCESS; else stay IDLE.
REQ-013 Single requester: that requester SHALL win.
REQ-014 Both requesting: SHALL grant the port that is not last_owner (round-robin); last_owner updates on each grant.
REQ-015 ACCESS: SHALL drive mem_en=1, mem_we=latched we, mem_addr/mem_wdata from latched values, for exactly one cycle.
REQ-016 ACCESS -> RESP when WAIT_STATES=0; otherwise -> WAIT with down-counter loaded to WAIT_STATES.
REQ-017 WAIT: mem_en=0, mem_we=0, mem_addr/mem_wdata held; counter decrements each cycle; -> RESP when counter reaches 1 (WAIT lasts exactly WAIT_STATES cycles).
REQ-018 On entry to RESP SHALL capture mem_rdata into rdata (reads and writes alike; rdata undefined-but-stable for writes).
REQ-019 RESP: SHALL pulse ack of owner for exactly one cycle, the other ack 0; then -> IDLE.
REQ-020 Latency: req high in IDLE at cycle n -> ack at cycle n+2+WAIT_STATES.
REQ-021 busy SHALL be 1 in ACCESS, WAIT, RESP; 0 in IDLE.
REQ-022 Requester SHALL hold req until ack and deassert it on the edge ending the ack cycle; req still high in the following IDLE is a new request.
REQ-023 Changes on requester addr/we/wdata after grant SHALL NOT affect the access in flight.
REQ-024 A req raised by the non-owner during an access SHALL wait; it SHALL be granted in the next IDLE.
REQ-025 At most one mem_en pulse per granted request; never two accesses in flight.

Reset
REQ-026 rst SHALL force: state IDLE, last_owner=1 (cpu wins first tie), owner=0, counter=0, rdata=0, busy=0, both acks 0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-027 rst asserted mid-access SHALL abort it: no ack, no further mem_en/mem_we pulse; first cycle after rst release is IDLE.

Configuration
REQ-028 Macro MEM_ARBITER_FIXED_PRIO_EN: defined -> cpu always wins ties (REQ-014 replaced), last_owner unused; undefined -> round-robin per REQ-014.

Verification
REQ-029 WAIT_STATES=0, cpu read addr 0x10, mem_rdata=0xDEADBEEF -> mem_en 1 cycle after req, cpu_ack cycle n+2, rdata=0xDEADBEEF, dbg_ack 0.
REQ-030 WAIT_STATES=3, dbg write addr 0x20 data 0x12345678 -> single mem_en+mem_we pulse with those values, dbg_ack at cycle n+5, busy high 5 cycles.
REQ-031 cpu_req and dbg_req held continuously from reset -> grants cpu, dbg, cpu, dbg (fixed-priority build: cpu every time).
REQ-032 cpu_addr changed 0x10->0x99 during WAIT -> mem_addr stays 0x10 until RESP completes.
REQ-033 rst pulsed during WAIT of a write -> no ack, no second mem_we, IDLE next cycle, all outputs at reset values.
REQ-034 dbg_req raised during cpu ACCESS -> cpu_ack first, dbg ACCESS starts one cycle after the IDLE that follows.
